muldiv_wb_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the single-cycle core. Sits between the register file read ports and its write port: consumes `rs1_data`/`rs2_data` for M-extension instructions, stalls the core while iterating, and drives the register file write interface (`reg_write`, `rd_sel`, `wb_data`) for exactly one cycle when the result is ready.

---
 rtl/muldiv_wb_unit.sv | 171 +++++++++++++++++
 tb/tb_muldiv_wb_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_wb_unit.sv
// Iterative RV32M multiply/divide unit driving the register-file write port.
// Define MULDIV_FAST_MUL_EN to route multiplies through a single-cycle multiplier.
module muldiv_wb_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            stall,
  output logic            busy,
  output logic            reg_write,
  output logic [4:0]      rd_sel,
  output logic [XLEN-1:0] wb_data
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_n;

  logic [XLEN-1:0] hi, lo, opb, res_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q, cnt;
  logic            neg_q;

  logic            load, load_spec, step, finish;

  // Operand decode, evaluated while IDLE
  logic            is_div, sign_a, sign_b, neg_a, neg_b;
  logic            div_zero, div_ovf, take_spec;
  logic [XLEN-1:0] a_mag, b_mag, spec_val;

  // Iteration datapath
  logic [XLEN:0]     mul_sum, div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   hi_n, lo_n;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   div_raw, fin_res;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN-1:0] fast_p;
`endif

  always_comb begin
    is_div   = funct3[2];
    sign_a   = (funct3 != 3'd3) && (funct3 != 3'd5) && (funct3 != 3'd7);
    sign_b   = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    neg_a    = sign_a && rs1_data[XLEN-1];
    neg_b    = sign_b && rs2_data[XLEN-1];
    a_mag    = neg_a ? ('0 - rs1_data) : rs1_data;
    b_mag    = neg_b ? ('0 - rs2_data) : rs2_data;
    div_zero = is_div && (rs2_data == '0);
    div_ovf  = is_div && !funct3[0] && (rs1_data == MIN_INT) && (rs2_data == '1);
    if (div_zero)
      spec_val = funct3[1] ? rs1_data : '1;
    else
      spec_val = funct3[1] ? '0 : MIN_INT;
    take_spec = div_zero || div_ovf;
`ifdef MULDIV_FAST_MUL_EN
    // Sign-extend to 33 bits so one signed multiply covers all four variants.
    fast_a = {sign_a && rs1_data[XLEN-1], rs1_data};
    fast_b = {sign_b && rs2_data[XLEN-1], rs2_data};
    fast_p = fast_a * fast_b;
    if (!is_div) begin
      take_spec = 1'b1;
      spec_val  = (funct3 == 3'd0) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
    end
`endif
  end

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opb};
    if (f3_q[2]) begin
      hi_n = div_ge ? (div_shift[XLEN-1:0] - opb) : div_shift[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], div_ge};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo[XLEN-1:1]};
    end
    prod_s  = neg_q ? ('0 - {hi_n, lo_n}) : {hi_n, lo_n};
    div_raw = f3_q[1] ? hi_n : lo_n;
    if (f3_q[2])
      fin_res = neg_q ? ('0 - div_raw) : div_raw;
    else
      fin_res = (f3_q == 3'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    load      = 1'b0;
    load_spec = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (take_spec) begin
            state_n   = DONE;
            load_spec = 1'b1;
          end else begin
            state_n = CALC;
            load    = 1'b1;
          end
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == 5'd31) begin
          state_n = DONE;
          finish  = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi    <= '0;
      lo    <= '0;
      opb   <= '0;
      res_q <= '0;
      f3_q  <= '0;
      rd_q  <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
    end else begin
      if (load) begin
        hi    <= '0;
        lo    <= a_mag;
        opb   <= b_mag;
        f3_q  <= funct3;
        rd_q  <= rd_in;
        cnt   <= '0;
        // Remainder follows the dividend only; everything else follows the operand-sign XOR.
        neg_q <= (funct3 == 3'd6) ? neg_a : (neg_a ^ neg_b);
      end else if (load_spec) begin
        f3_q  <= funct3;
        rd_q  <= rd_in;
        res_q <= spec_val;
      end
      if (step) begin
        hi  <= hi_n;
        lo  <= lo_n;
        cnt <= cnt + 5'd1;
        if (finish) res_q <= fin_res;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign stall     = busy || start;
  assign reg_write = (state == DONE) && (rd_q != 5'd0);
  assign rd_sel    = rd_q;
  assign wb_data   = res_q;

endmodule

// File: tb/tb_muldiv_wb_unit.sv
// Directed bench for muldiv_wb_unit with a small register-file model on the write port.
module tb_muldiv_wb_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_K = 0;
`else
  localparam int MUL_K = 32;
`endif
  localparam int DIV_K = 32;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        stall, busy, reg_write;
  logic [4:0]  rd_sel;
  logic [31:0] wb_data;

  int vec  = 0;
  int errs = 0;

  logic [31:0] regs [32] = '{default: '0};
  int          wr_count = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    int          k;
  } vec_t;

  muldiv_wb_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .stall(stall), .busy(busy), .reg_write(reg_write),
    .rd_sel(rd_sel), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reg_write) begin
      wr_count <= wr_count + 1;
      if (rd_sel != 5'd0) regs[rd_sel] <= wb_data;
    end
  end

  // Drives one instruction and measures its write-back; k counts samples taken #1 after each edge from E0 on.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int we_k, output int we_n, output int idle_k,
                       output int sc, output logic [4:0] got_rd, output logic [31:0] got_d,
                       output bit to);
    int k;
    @(negedge clk);
    funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
    #1;
    sc = stall ? 1 : 0;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; we_k = -1; we_n = 0; idle_k = -1; to = 1'b0; got_rd = '0; got_d = '0;
    while (busy && k < 100) begin
      if (stall) sc++;
      if (reg_write) begin
        we_n++; we_k = k; got_rd = rd_sel; got_d = wb_data;
      end
      @(posedge clk); #1;
      k++;
    end
    if (busy) to = 1'b1;
    else idle_k = k;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
    #1;
    vec++; if (busy !== 1'b0)      begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec++; if (reg_write !== 1'b0) begin errs++; $display("FAIL reset_reg_write: got %b want 0", reg_write); end
    vec++; if (stall !== 1'b0)     begin errs++; $display("FAIL reset_stall: got %b want 0", stall); end
    vec++; if (rd_sel !== 5'd0)    begin errs++; $display("FAIL reset_rd_sel: got %0d want 0", rd_sel); end
    vec++; if (wb_data !== 32'h0)  begin errs++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mul_basic;
    int we_k, we_n, idle_k, sc; logic [4:0] grd; logic [31:0] gd; bit to;
    issue(3'd0, 32'd7, 32'd6, 5'd5, we_k, we_n, idle_k, sc, grd, gd, to);
    vec++; if (to !== 1'b0)        begin errs++; $display("FAIL mul_timeout: busy never dropped"); end
    vec++; if (we_n !== 1)         begin errs++; $display("FAIL mul_write_count: got %0d want 1", we_n); end
    vec++; if (grd !== 5'd5)       begin errs++; $display("FAIL mul_rd_sel: got %0d want 5", grd); end
    vec++; if (gd !== 32'h2A)      begin errs++; $display("FAIL mul_wb_data: got %h want 0000002a", gd); end
    vec++; if (we_k !== MUL_K)     begin errs++; $display("FAIL mul_write_cycle: got %0d want %0d", we_k, MUL_K); end
    vec++; if (idle_k !== MUL_K+1) begin errs++; $display("FAIL mul_idle_cycle: got %0d want %0d", idle_k, MUL_K+1); end
    vec++; if (sc !== MUL_K+2)     begin errs++; $display("FAIL mul_stall_cycles: got %0d want %0d", sc, MUL_K+2); end
    vec++; if (stall !== 1'b0)     begin errs++; $display("FAIL mul_stall_after: got %b want 0", stall); end
    vec++; if (regs[5] !== 32'h2A) begin errs++; $display("FAIL mul_x5: got %h want 0000002a", regs[5]); end
  endtask

  task automatic test_arith;
    vec_t tbl[$];
    int we_k, we_n, idle_k, sc; logic [4:0] grd; logic [31:0] gd; bit to;
    tbl.push_back('{3'd4, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, DIV_K});
    tbl.push_back('{3'd6, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, DIV_K});
    tbl.push_back('{3'd4, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, DIV_K});
    tbl.push_back('{3'd6, 32'd20,       32'hFFFFFFFD, 32'd2,        DIV_K});
    tbl.push_back('{3'd5, 32'd100,      32'd7,        32'd14,       DIV_K});
    tbl.push_back('{3'd7, 32'd100,      32'd7,        32'd2,        DIV_K});
    tbl.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_K});
    tbl.push_back('{3'd1, 32'hFFFFFFFE, 32'h80000000, 32'h00000001, MUL_K});
    tbl.push_back('{3'd2, 32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFFF, MUL_K});
    tbl.push_back('{3'd3, 32'hFFFFFFFE, 32'h80000000, 32'h7FFFFFFF, MUL_K});
    tbl.push_back('{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, MUL_K});
    foreach (tbl[i]) begin
      issue(tbl[i].f, tbl[i].a, tbl[i].b, 5'd7, we_k, we_n, idle_k, sc, grd, gd, to);
      vec++; if (gd !== tbl[i].e)  begin errs++; $display("FAIL arith_data[%0d]: got %h want %h", i, gd, tbl[i].e); end
      vec++; if (we_k !== tbl[i].k) begin errs++; $display("FAIL arith_cycle[%0d]: got %0d want %0d", i, we_k, tbl[i].k); end
    end
    vec++; if (regs[7] !== 32'hFFFFFFF1) begin errs++; $display("FAIL arith_x7: got %h want fffffff1", regs[7]); end
  endtask

  task automatic test_special;
    vec_t tbl[$];
    int we_k, we_n, idle_k, sc; logic [4:0] grd; logic [31:0] gd; bit to;
    tbl.push_back('{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 0});
    tbl.push_back('{3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 0});
    tbl.push_back('{3'd7, 32'h1234,     32'd0,        32'h00001234, 0});
    tbl.push_back('{3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 0});
    tbl.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0});
    tbl.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0});
    foreach (tbl[i]) begin
      issue(tbl[i].f, tbl[i].a, tbl[i].b, 5'd11, we_k, we_n, idle_k, sc, grd, gd, to);
      vec++; if (gd !== tbl[i].e) begin errs++; $display("FAIL special_data[%0d]: got %h want %h", i, gd, tbl[i].e); end
      vec++; if (we_k !== 0)      begin errs++; $display("FAIL special_cycle[%0d]: got %0d want 0", i, we_k); end
      vec++; if (sc !== 2)        begin errs++; $display("FAIL special_stall[%0d]: got %0d want 2", i, sc); end
    end
    vec++; if (idle_k !== 1) begin errs++; $display("FAIL special_idle: got %0d want 1", idle_k); end
  endtask

  task automatic test_rd_zero;
    int we_k, we_n, idle_k, sc, w0; logic [4:0] grd; logic [31:0] gd; bit to;
    w0 = wr_count;
    issue(3'd0, 32'd3, 32'd5, 5'd0, we_k, we_n, idle_k, sc, grd, gd, to);
    vec++; if (we_n !== 0)          begin errs++; $display("FAIL rd0_strobes: got %0d want 0", we_n); end
    vec++; if (idle_k !== MUL_K+1)  begin errs++; $display("FAIL rd0_idle_cycle: got %0d want %0d", idle_k, MUL_K+1); end
    vec++; if (wr_count !== w0)     begin errs++; $display("FAIL rd0_writes: got %0d want %0d", wr_count, w0); end
  endtask

  task automatic test_reset_mid;
    int we_k, we_n, idle_k, sc, w0; logic [4:0] grd; logic [31:0] gd; bit to;
    w0 = wr_count;
    @(negedge clk);
    funct3 = 3'd4; rs1_data = 32'hFFFFFFEC; rs2_data = 32'd3; rd_in = 5'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    vec++; if (busy !== 1'b0)      begin errs++; $display("FAIL rmid_busy: got %b want 0", busy); end
    vec++; if (stall !== 1'b0)     begin errs++; $display("FAIL rmid_stall: got %b want 0", stall); end
    vec++; if (reg_write !== 1'b0) begin errs++; $display("FAIL rmid_reg_write: got %b want 0", reg_write); end
    vec++; if (wb_data !== 32'h0)  begin errs++; $display("FAIL rmid_wb_data: got %h want 0", wb_data); end
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    vec++; if (wr_count !== w0)    begin errs++; $display("FAIL rmid_no_write: got %0d want %0d", wr_count, w0); end
    vec++; if (regs[12] !== 32'h0) begin errs++; $display("FAIL rmid_x12: got %h want 0", regs[12]); end
    issue(3'd5, 32'd100, 32'd7, 5'd9, we_k, we_n, idle_k, sc, grd, gd, to);
    vec++; if (gd !== 32'd14)      begin errs++; $display("FAIL rmid_next_data: got %h want 0000000e", gd); end
    vec++; if (we_k !== DIV_K)     begin errs++; $display("FAIL rmid_next_cycle: got %0d want %0d", we_k, DIV_K); end
    vec++; if (regs[9] !== 32'd14) begin errs++; $display("FAIL rmid_x9: got %h want 0000000e", regs[9]); end
  endtask

  task automatic test_back_to_back;
    int pos[2]; int n, w0, dw, k;
    logic [31:0] d[2];
    logic busy_mid, stall_mid;
    n = 0; pos[0] = -1; pos[1] = -1; d[0] = '0; d[1] = '0; busy_mid = 1'b1; stall_mid = 1'b0;
    @(negedge clk);
    funct3 = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd3; start = 1'b1;
    w0 = wr_count;
    @(posedge clk); #1;
    for (int i = 0; i < 70; i++) begin
      if (reg_write) begin
        if (n < 2) begin pos[n] = i; d[n] = wb_data; end
        n++;
      end
      if (i == 33) begin busy_mid = busy; stall_mid = stall; end
      @(posedge clk); #1;
    end
    dw = wr_count - w0;
    start = 1'b0;
    k = 0;
    while (busy && k < 50) begin @(posedge clk); #1; k++; end
    vec++; if (busy !== 1'b0)      begin errs++; $display("FAIL b2b_timeout: busy still %b", busy); end
    vec++; if (n !== 2)            begin errs++; $display("FAIL b2b_strobes: got %0d want 2", n); end
    vec++; if (pos[0] !== 32)      begin errs++; $display("FAIL b2b_first_cycle: got %0d want 32", pos[0]); end
    vec++; if (pos[1] !== 66)      begin errs++; $display("FAIL b2b_second_cycle: got %0d want 66", pos[1]); end
    vec++; if (busy_mid !== 1'b0)  begin errs++; $display("FAIL b2b_gap_busy: got %b want 0", busy_mid); end
    vec++; if (stall_mid !== 1'b1) begin errs++; $display("FAIL b2b_gap_stall: got %b want 1", stall_mid); end
    vec++; if (dw !== 2)           begin errs++; $display("FAIL b2b_writes: got %0d want 2", dw); end
    vec++; if (d[1] !== 32'd14)    begin errs++; $display("FAIL b2b_second_data: got %h want 0000000e", d[1]); end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_arith();
    test_special();
    test_rd_zero();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
